// File: rtl/dnn_fix_pkg.sv
// Shared definitions for the fixed-point MNIST inference datapath:
// default score geometry, the signed score type, the argmax FSM states,
// and the most negative representable score.
package dnn_fix_pkg;

  localparam int unsigned DNN_DATA_WIDTH = 16;
  localparam int unsigned DNN_N_CLASSES  = 10;

  typedef logic signed [DNN_DATA_WIDTH-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } argmax_state_t;

  localparam score_t SCORE_MIN = {1'b1, {(DNN_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/dnn_argmax_fix_if.sv
// Classifier result interface: score snapshot request, consumer ack and
// registered result outputs. With DNN_ARGMAX_MARGIN_EN defined the
// confidence outputs (margin, low_conf) are also carried.
interface dnn_argmax_fix_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_CLASSES  = 10,
  parameter int unsigned IDX_WIDTH  = 4
);

  logic                                 start;
  logic [N_CLASSES-1:0][DATA_WIDTH-1:0] scores;
  logic                                 ack;
  logic                                 busy;
  logic                                 valid;
  logic [IDX_WIDTH-1:0]                 digit;
  logic [DATA_WIDTH-1:0]                max_score;
  logic                                 overrun;
`ifdef DNN_ARGMAX_MARGIN_EN
  logic [DATA_WIDTH:0]                  margin;
  logic                                 low_conf;

  modport master (
    output start, scores, ack,
    input  busy, valid, digit, max_score, overrun, margin, low_conf
  );

  modport slave (
    input  start, scores, ack,
    output busy, valid, digit, max_score, overrun, margin, low_conf
  );
`else
  modport master (
    output start, scores, ack,
    input  busy, valid, digit, max_score, overrun
  );

  modport slave (
    input  start, scores, ack,
    output busy, valid, digit, max_score, overrun
  );
`endif

endinterface

// File: rtl/dnn_top2_update.sv
// Combinational running-max update against one candidate score.
// Strictly-greater replaces the best, so ties keep the lower index.
// With DNN_ARGMAX_MARGIN_EN the runner-up is tracked as well: a new best
// demotes the old best, otherwise a candidate above the runner-up replaces it.
module dnn_top2_update #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic signed [DATA_WIDTH-1:0] best_i,
  input  logic        [IDX_WIDTH-1:0]  best_idx_i,
`ifdef DNN_ARGMAX_MARGIN_EN
  input  logic signed [DATA_WIDTH-1:0] second_i,
  output logic signed [DATA_WIDTH-1:0] second_o,
`endif
  input  logic signed [DATA_WIDTH-1:0] cand_i,
  input  logic        [IDX_WIDTH-1:0]  cand_idx_i,
  output logic signed [DATA_WIDTH-1:0] best_o,
  output logic        [IDX_WIDTH-1:0]  best_idx_o
);

  // Compare candidate against the running best (and runner-up)
  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
`ifdef DNN_ARGMAX_MARGIN_EN
    second_o   = second_i;
`endif
    if (cand_i > best_i) begin
      best_o     = cand_i;
      best_idx_o = cand_idx_i;
`ifdef DNN_ARGMAX_MARGIN_EN
      second_o   = best_i;
    end else if (cand_i > second_i) begin
      second_o   = cand_i;
`endif
    end
  end

endmodule

// File: rtl/dnn_argmax_fix.sv
// Argmax classifier stage: snapshots N_CLASSES signed scores on start,
// scans one per clock and presents the winning digit and score with a
// valid/ack handshake. Optional feature macro: DNN_ARGMAX_MARGIN_EN adds
// best-minus-second margin and a low-confidence flag.
module dnn_argmax_fix
  import dnn_fix_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DNN_DATA_WIDTH,
  parameter int unsigned N_CLASSES     = DNN_N_CLASSES,
  parameter int unsigned IDX_WIDTH     = 4,
  parameter int unsigned MARGIN_THRESH = 256
) (
  input logic             clk,
  input logic             rst,
  dnn_argmax_fix_if.slave bus
);

  typedef logic signed [DATA_WIDTH-1:0] sc_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_CLASSES - 1);
`ifdef DNN_ARGMAX_MARGIN_EN
  localparam sc_t MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  argmax_state_t        state_q, state_d;
  sc_t                  snap_q [N_CLASSES];
  sc_t                  snap_d [N_CLASSES];
  sc_t                  best_q, best_d;
  logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [IDX_WIDTH-1:0] digit_q, digit_d;
  sc_t                  max_score_q, max_score_d;
  logic                 overrun_q, overrun_d;
  logic                 accept;

  sc_t                  upd_best;
  logic [IDX_WIDTH-1:0] upd_idx;

`ifdef DNN_ARGMAX_MARGIN_EN
  sc_t                  second_q, second_d;
  sc_t                  upd_second;
  logic [DATA_WIDTH:0]  margin_q, margin_d;
  logic [DATA_WIDTH:0]  margin_next;
  logic                 low_conf_q, low_conf_d;
`endif

  dnn_top2_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_top2 (
    .best_i     (best_q),
    .best_idx_i (best_idx_q),
`ifdef DNN_ARGMAX_MARGIN_EN
    .second_i   (second_q),
    .second_o   (upd_second),
`endif
    .cand_i     (snap_q[idx_q]),
    .cand_idx_i (idx_q),
    .best_o     (upd_best),
    .best_idx_o (upd_idx)
  );

  // Next-state and datapath: scan, commit, handshake and overrun tracking
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    digit_d     = digit_q;
    max_score_d = max_score_q;
    overrun_d   = overrun_q;
`ifdef DNN_ARGMAX_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
    low_conf_d  = low_conf_q;
    // Sign-extend both operands one bit so the difference is exact and non-negative
    margin_next = {upd_best[DATA_WIDTH-1], upd_best} - {upd_second[DATA_WIDTH-1], upd_second};
`endif
    accept = bus.start && ((state_q == IDLE) || ((state_q == HOLD) && bus.ack));

    unique case (state_q)
      IDLE: ;
      SCAN: begin
        if (bus.start) overrun_d = 1'b1;
        best_d     = upd_best;
        best_idx_d = upd_idx;
        idx_d      = idx_q + 1'b1;
`ifdef DNN_ARGMAX_MARGIN_EN
        second_d   = upd_second;
`endif
        if (idx_q == LAST_IDX) begin
          state_d     = HOLD;
          busy_d      = 1'b0;
          valid_d     = 1'b1;
          digit_d     = upd_idx;
          max_score_d = upd_best;
`ifdef DNN_ARGMAX_MARGIN_EN
          margin_d    = margin_next;
          low_conf_d  = (margin_next < (DATA_WIDTH+1)'(MARGIN_THRESH));
`endif
        end
      end
      HOLD: begin
        if (bus.ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (bus.start) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start taken together with ack in HOLD overrides the return to IDLE
    if (accept) begin
      for (int unsigned i = 0; i < N_CLASSES; i++) snap_d[i] = sc_t'(bus.scores[i]);
      best_d     = sc_t'(bus.scores[0]);
      best_idx_d = '0;
      idx_d      = IDX_WIDTH'(1);
      busy_d     = 1'b1;
      state_d    = SCAN;
`ifdef DNN_ARGMAX_MARGIN_EN
      second_d   = MIN_SCORE;
`endif
    end
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < N_CLASSES; i++) snap_q[i] <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      digit_q     <= '0;
      max_score_q <= '0;
      overrun_q   <= 1'b0;
`ifdef DNN_ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
      low_conf_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      digit_q     <= digit_d;
      max_score_q <= max_score_d;
      overrun_q   <= overrun_d;
`ifdef DNN_ARGMAX_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
      low_conf_q  <= low_conf_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.digit     = digit_q;
  assign bus.max_score = max_score_q;
  assign bus.overrun   = overrun_q;
`ifdef DNN_ARGMAX_MARGIN_EN
  assign bus.margin    = margin_q;
  assign bus.low_conf  = low_conf_q;
`endif

endmodule

// File: tb/tb_dnn_argmax_fix.sv
// Directed bench for dnn_argmax_fix (default geometry: 16-bit scores, 10 classes).
// Honours DNN_ARGMAX_MARGIN_EN for the margin/low_conf outputs.
module tb_dnn_argmax_fix;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dnn_argmax_fix_if #(.DATA_WIDTH(16), .N_CLASSES(10), .IDX_WIDTH(4)) bus ();

  dnn_argmax_fix #(
    .DATA_WIDTH    (16),
    .N_CLASSES     (10),
    .IDX_WIDTH     (4),
    .MARGIN_THRESH (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 10; i++) bus.scores[i] = v;
  endtask

  // Pulse start for the sampling edge
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Edges 1..8 after the sampling edge must not show valid; edge 9 commits
  task automatic wait_result(input string tag, input logic [3:0] e_dig, input logic [15:0] e_max,
                             input logic [16:0] e_margin, input logic e_low);
    for (int i = 0; i < 8; i++) tick();
    chk({tag, "_valid_early"}, 32'(bus.valid), 32'd0);
    chk({tag, "_busy_scan"},   32'(bus.busy),  32'd1);
    tick();
    chk({tag, "_valid"},  32'(bus.valid),     32'd1);
    chk({tag, "_busy"},   32'(bus.busy),      32'd0);
    chk({tag, "_digit"},  32'(bus.digit),     32'(e_dig));
    chk({tag, "_max"},    32'(bus.max_score), 32'(e_max));
`ifdef DNN_ARGMAX_MARGIN_EN
    chk({tag, "_margin"}, 32'(bus.margin),    32'(e_margin));
    chk({tag, "_lowc"},   32'(bus.low_conf),  32'(e_low));
`else
    if (e_low === 1'bx || e_margin === 'x) $display("[TB] note: bad margin vector");
`endif
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack_clears_valid", 32'(bus.valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    fill(16'h0000);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy",    32'(bus.busy),      32'd0);
    chk("rst_valid",   32'(bus.valid),     32'd0);
    chk("rst_digit",   32'(bus.digit),     32'd0);
    chk("rst_max",     32'(bus.max_score), 32'd0);
    chk("rst_overrun", 32'(bus.overrun),   32'd0);
`ifdef DNN_ARGMAX_MARGIN_EN
    chk("rst_margin",  32'(bus.margin),    32'd0);
    chk("rst_lowc",    32'(bus.low_conf),  32'd0);
`endif

    // Single peak at index 7; scores changed right after start must not matter
    fill(16'h0000);
    bus.scores[7] = 16'h1200;
    pulse_start();
    fill(16'h7FFF);
    chk("peak_busy_after_start", 32'(bus.busy), 32'd1);
    wait_result("peak", 4'd7, 16'h1200, 17'h01200, 1'b0);
    do_ack();

    // Tie between 2 and 5: lower index wins, margin zero
    fill(16'h0100);
    bus.scores[2] = 16'h4000;
    bus.scores[5] = 16'h4000;
    pulse_start();
    wait_result("tie", 4'd2, 16'h4000, 17'h00000, 1'b1);
    do_ack();

    // All negative, last index holds the largest
    fill(16'hFF9C);
    bus.scores[9] = 16'hFFFF;
    pulse_start();
    wait_result("neg", 4'd9, 16'hFFFF, 17'h00063, 1'b1);
    do_ack();

    // Full-range spread: 0x7FFF over 0x8000
    fill(16'h8000);
    bus.scores[0] = 16'h7FFF;
    pulse_start();
    wait_result("range", 4'd0, 16'h7FFF, 17'h0FFFF, 1'b0);
    do_ack();

    // Margin exactly at threshold is not low confidence
    fill(16'h0000);
    bus.scores[0] = 16'h4000;
    bus.scores[3] = 16'h3F00;
    pulse_start();
    wait_result("thresh", 4'd0, 16'h4000, 17'h00100, 1'b0);
    do_ack();

    // Start during SCAN (cycle 4) and during HOLD without ack: both ignored, overrun sticks
    fill(16'h0010);
    bus.scores[4] = 16'h0500;
    pulse_start();
    tick();
    tick();
    tick();
    fill(16'h0000);
    bus.scores[1] = 16'h7000;
    pulse_start();
    chk("ovr_set",  32'(bus.overrun), 32'd1);
    chk("ovr_busy", 32'(bus.busy),    32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("ovr_valid_early", 32'(bus.valid), 32'd0);
    tick();
    chk("ovr_valid", 32'(bus.valid),     32'd1);
    chk("ovr_digit", 32'(bus.digit),     32'd4);
    chk("ovr_max",   32'(bus.max_score), 32'h0500);
`ifdef DNN_ARGMAX_MARGIN_EN
    chk("ovr_margin", 32'(bus.margin), 32'h004F0);
`endif
    pulse_start();
    chk("hold_start_valid",   32'(bus.valid),   32'd1);
    chk("hold_start_busy",    32'(bus.busy),    32'd0);
    chk("hold_start_digit",   32'(bus.digit),   32'd4);
    chk("hold_start_overrun", 32'(bus.overrun), 32'd1);
    do_ack();
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);

    // ack and start together in HOLD: new scan, no overrun
    fill(16'h0000);
    bus.scores[6] = 16'h0333;
    pulse_start();
    wait_result("pre_ackstart", 4'd6, 16'h0333, 17'h00333, 1'b0);
    fill(16'hFFF0);
    bus.scores[8] = 16'h0042;
    bus.ack   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    chk("ackstart_valid",   32'(bus.valid),   32'd0);
    chk("ackstart_busy",    32'(bus.busy),    32'd1);
    chk("ackstart_overrun", 32'(bus.overrun), 32'd0);
    wait_result("ackstart", 4'd8, 16'h0042, 17'h00052, 1'b1);
    chk("ackstart_overrun_end", 32'(bus.overrun), 32'd0);
    do_ack();

    // Reset in the middle of a scan discards it
    fill(16'h0000);
    bus.scores[5] = 16'h0700;
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy",  32'(bus.busy),      32'd0);
    chk("midrst_valid", 32'(bus.valid),     32'd0);
    chk("midrst_digit", 32'(bus.digit),     32'd0);
    chk("midrst_max",   32'(bus.max_score), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_stays_idle", 32'(bus.valid), 32'd0);
    fill(16'h0000);
    bus.scores[3] = 16'h0123;
    pulse_start();
    wait_result("postrst", 4'd3, 16'h0123, 17'h00123, 1'b0);
    do_ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
